csa_mult4_unit: RTL and testbench

// - Registered 4x4 unsigned multiplier built as a carry-save array of base cells.
// - Each base cell is a full adder with a partial-product AND; a ripple vector-merge

---
 rtl/csa_mult4_unit.sv | 102 ++++++++++
 tb/tb_csa_mult4_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/csa_mult4_unit.sv
// Registered 4x4 unsigned multiplier: carry-save array of AND+adder base cells
// closed by a 4-bit ripple merge adder, one-cycle latency, one result per cycle.
module csa_mult4_unit #(
   parameter int ARCH   = 0,
   parameter int PROD_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [3:0]        a,
   input  logic [3:0]        b,
   output logic [PROD_W-1:0] product,
   output logic              out_valid
);

   // Valid semantics: in_valid=1 at a rising edge captures a*b into product and
   // raises out_valid for the following cycle only; there is no ready/stall path.

   logic [3:0][3:0] w_pp;
   logic [3:0][3:0] w_s;
   logic [3:0][3:0] w_c;
   logic [3:0]      w_sh;
   logic            w_x;
   logic            w_y;
   logic            w_z;
   logic            w_mc;
   logic [7:0]      w_prod;

   logic [PROD_W-1:0] r_product;
   logic              r_valid;

   always_comb begin
      w_pp   = '0;
      w_s    = '0;
      w_c    = '0;
      w_sh   = '0;
      w_x    = 1'b0;
      w_y    = 1'b0;
      w_z    = 1'b0;
      w_mc   = 1'b0;
      w_prod = '0;

      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            w_pp[i][j] = a[j] & b[i];
         end
      end

      // Row 0 is the bare partial-product row; it carries nothing yet.
      w_s[0] = w_pp[0];
      w_c[0] = '0;

      // Each row shifts the previous sum right by one weight position; carries
      // stay in their column (no horizontal propagation inside the array).
      for (int i = 1; i < 4; i++) begin
         w_sh = {1'b0, w_s[i-1][3:1]};
         for (int j = 0; j < 4; j++) begin
            w_x = w_pp[i][j];
            w_y = w_sh[j];
            w_z = w_c[i-1][j];
            if ((ARCH == 1) && (i == 1)) begin
               w_s[i][j] = w_x ^ w_y;
               w_c[i][j] = w_x & w_y;
            end else begin
               w_s[i][j] = w_x ^ w_y ^ w_z;
               w_c[i][j] = (w_x & w_y) | (w_x & w_z) | (w_y & w_z);
            end
         end
      end

      w_prod[0] = w_s[0][0];
      w_prod[1] = w_s[1][0];
      w_prod[2] = w_s[2][0];
      w_prod[3] = w_s[3][0];

      // Vector-merge ripple adder; its carry out of bit 7 is always 0 (max 225).
      w_sh = {1'b0, w_s[3][3:1]};
      w_mc = 1'b0;
      for (int k = 0; k < 4; k++) begin
         w_x           = w_sh[k];
         w_y           = w_c[3][k];
         w_prod[4 + k] = w_x ^ w_y ^ w_mc;
         w_mc          = (w_x & w_y) | (w_x & w_mc) | (w_y & w_mc);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_product <= '0;
         r_valid   <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_product <= PROD_W'(w_prod);
         end
      end
   end

   assign product   = r_product;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_csa_mult4_unit.sv
// Bench for csa_mult4_unit: both array variants driven in parallel, a queue
// scoreboard of a*b, and directed reset/hold checks.
module tb_csa_mult4_unit;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [3:0] a;
   logic [3:0] b;
   logic [8:0] product0;
   logic [8:0] product1;
   logic       out_valid0;
   logic       out_valid1;

   logic [8:0] exp_q[$];
   int         n_checks;
   int         n_fail;

   csa_mult4_unit #(.ARCH(0), .PROD_W(9)) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .product   (product0),
      .out_valid (out_valid0)
   );

   csa_mult4_unit #(.ARCH(1), .PROD_W(9)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .product   (product1),
      .out_valid (out_valid1)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic issue(input logic [3:0] ta, input logic [3:0] tb_v);
      int p;
      in_valid = 1'b1;
      a        = ta;
      b        = tb_v;
      p        = int'(ta) * int'(tb_v);
      exp_q.push_back(9'(p));
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // monitor / scoreboard
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         check("arch_valid_agree", {8'd0, out_valid1}, {8'd0, out_valid0});
         if (out_valid0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", {8'd0, out_valid0}, 9'd0);
            end else begin
               e = exp_q.pop_front();
               check("product_arch0", product0, e);
               check("product_arch1", product1, e);
               check("product_msb_zero", {8'd0, product0[8]}, 9'd0);
            end
         end
      end
   end

   localparam int N_DIR = 8;
   logic [3:0] dir_a [N_DIR] = '{4'd3, 4'd10, 4'd9,  4'd6, 4'd15, 4'd0,  4'd5,  4'd11};
   logic [3:0] dir_b [N_DIR] = '{4'd4, 4'd7,  4'd14, 4'd6, 4'd15, 4'd12, 4'd13, 4'd11};

   initial begin
      int drain;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      in_valid = 1'b1;
      a        = 4'd15;
      b        = 4'd15;

      // Reset held two cycles with a live operand pair that must be discarded.
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         check("reset_product", product0, 9'd0);
         check("reset_out_valid", {8'd0, out_valid0}, 9'd0);
      end
      rst = 1'b0;

      // Directed products back-to-back.
      for (int k = 0; k < N_DIR; k++) begin
         issue(dir_a[k], dir_b[k]);
      end

      // Hold: in_valid low, operands change, product keeps 121.
      in_valid = 1'b0;
      a        = 4'd2;
      b        = 4'd3;
      @(posedge clk);
      #1;
      check("hold_product", product0, 9'd121);
      check("hold_out_valid", {8'd0, out_valid0}, 9'd0);
      a = 4'bxxxx;
      b = 4'bxxxx;
      @(posedge clk);
      #1;
      check("hold_unknown_product", product1, 9'd121);

      // Reset mid-stream with a simultaneous valid pair.
      issue(4'd7, 4'd9);
      rst      = 1'b1;
      in_valid = 1'b1;
      a        = 4'd5;
      b        = 4'd13;
      @(posedge clk);
      #1;
      check("midrst_product", product0, 9'd0);
      check("midrst_out_valid", {8'd0, out_valid0}, 9'd0);
      rst = 1'b0;
      idle();
      check("post_rst_product", product1, 9'd0);
      check("post_rst_out_valid", {8'd0, out_valid1}, 9'd0);

      // Exhaustive sweep, back-to-back.
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            issue(4'(ia), 4'(ib));
         end
      end

      // Random operands with random idle gaps.
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle();
         end
         issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      in_valid = 1'b0;
      drain    = 0;
      while ((exp_q.size() != 0) && (drain < 10)) begin
         @(posedge clk);
         #1;
         drain++;
      end
      @(posedge clk);
      #1;
      check("scoreboard_drained", 9'(exp_q.size()), 9'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
